// File: rtl/j1_uart_io_if.sv
// J1 I/O bus bundle between the CPU core (master) and a memory-mapped
// peripheral (slave): write strobe, address, write data and read data.
interface j1_uart_io_if #(
  parameter int WIDTH = 16
);
  logic             io_wr;
  logic [15:0]      mem_addr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] io_din;

  modport master (
    output io_wr,
    output mem_addr,
    output dout,
    input  io_din
  );

  modport slave (
    input  io_wr,
    input  mem_addr,
    input  dout,
    output io_din
  );
endinterface

// File: rtl/j1_uart_io.sv
// Memory-mapped 8N1 UART for the J1 I/O bus: TXDATA/RXDATA/STATUS/RXACK at
// BASE+0..3, one transmitter and one mid-bit-sampling receiver.
module j1_uart_io #(
  parameter int          WIDTH        = 16,
  parameter logic [15:0] BASE         = 16'h1000,
  parameter int          CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        resetq,
  j1_uart_io_if.slave bus,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] ADDR_TX   = BASE;
  localparam logic [15:0] ADDR_RXD  = BASE + 16'd1;
  localparam logic [15:0] ADDR_STAT = BASE + 16'd2;
  localparam logic [15:0] ADDR_ACK  = BASE + 16'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uartState_t;

  uartState_t r_txState, w_txStateNext;
  logic [CW-1:0] r_txCnt, w_txCntNext;
  logic [2:0]    r_txBit, w_txBitNext;
  logic [7:0]    r_txData;
  logic          r_tx, w_txOut, w_txLoad, w_txBusy, w_txWrite, w_txLast;

  uartState_t r_rxState, w_rxStateNext;
  logic [CW-1:0] r_rxCnt, w_rxCntNext;
  logic [2:0]    r_rxBit, w_rxBitNext;
  logic [1:0]    r_rxSync;
  logic [7:0]    r_rxShift, r_rxData;
  logic          r_rxValid, r_ovr, r_ferr;
  logic          w_rxIn, w_rxLast, w_rxShiftEn, w_rxDone, w_ack, w_validAfterAck;
  logic [WIDTH-1:0] w_rdata;
  logic          w_unused;

  assign w_txWrite = bus.io_wr && (bus.mem_addr == ADDR_TX);
  assign w_ack     = bus.io_wr && (bus.mem_addr == ADDR_ACK);
  assign w_txLast  = (r_txCnt == CNT_LAST);
  assign w_rxLast  = (r_rxCnt == CNT_LAST);
  assign w_rxIn    = r_rxSync[1];
  assign w_unused  = &{1'b0, bus.dout[WIDTH-1:8]};

  // Transmitter: state and bit-timing registers; the line is registered from
  // the next state so the start bit appears right after the accepting edge.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_txState <= ST_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txData  <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_tx      <= w_txOut;
      if (w_txLoad) r_txData <= bus.dout[7:0];
    end
  end

  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txBitNext   = r_txBit;
    w_txLoad      = 1'b0;
    case (r_txState)
      ST_IDLE: begin
        w_txCntNext = '0;
        if (w_txWrite) begin
          w_txStateNext = ST_START;
          w_txLoad      = 1'b1;
        end
      end
      ST_START: if (w_txLast) begin
        w_txStateNext = ST_DATA;
        w_txCntNext   = '0;
        w_txBitNext   = '0;
      end
      ST_DATA: if (w_txLast) begin
        w_txCntNext = '0;
        if (r_txBit == 3'd7) w_txStateNext = ST_STOP;
        else                 w_txBitNext   = r_txBit + 3'd1;
      end
      default: if (w_txLast) begin
        w_txStateNext = ST_IDLE;
        w_txCntNext   = '0;
      end
    endcase
  end

  always_comb begin
    w_txBusy = (r_txState != ST_IDLE);
    case (w_txStateNext)
      ST_START: w_txOut = 1'b0;
      ST_DATA:  w_txOut = r_txData[w_txBitNext];
      default:  w_txOut = 1'b1;
    endcase
  end

  assign uart_tx = r_tx;

  // Receiver: synchronizer, state and counters, plus the flag registers; an
  // ack in the same cycle as a completion is applied first.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rxSync  <= 2'b11;
      r_rxState <= ST_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rxSync  <= {r_rxSync[0], uart_rx};
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      if (w_rxShiftEn) r_rxShift <= {w_rxIn, r_rxShift[7:1]};
      if (w_ack) begin
        r_rxValid <= 1'b0;
        r_ovr     <= 1'b0;
        r_ferr    <= 1'b0;
      end
      if (w_rxDone) begin
        if (!w_rxIn) begin
          r_ferr <= 1'b1;
        end else if (!w_validAfterAck) begin
          r_rxData  <= r_rxShift;
          r_rxValid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt + 1'b1;
    w_rxBitNext   = r_rxBit;
    w_rxShiftEn   = 1'b0;
    w_rxDone      = 1'b0;
    case (r_rxState)
      ST_IDLE: begin
        w_rxCntNext = '0;
        if (!w_rxIn) w_rxStateNext = ST_START;
      end
      ST_START: if (r_rxCnt == HALF_LAST) begin
        w_rxCntNext   = '0;
        w_rxBitNext   = '0;
        w_rxStateNext = w_rxIn ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (w_rxLast) begin
        w_rxCntNext = '0;
        w_rxShiftEn = 1'b1;
        if (r_rxBit == 3'd7) w_rxStateNext = ST_STOP;
        else                 w_rxBitNext   = r_rxBit + 3'd1;
      end
      default: if (w_rxLast) begin
        w_rxCntNext   = '0;
        w_rxDone      = 1'b1;
        w_rxStateNext = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_validAfterAck = r_rxValid && !w_ack;
    w_rdata         = '0;
    if (bus.mem_addr == ADDR_RXD)
      w_rdata = {{(WIDTH-8){1'b0}}, r_rxData};
    else if (bus.mem_addr == ADDR_STAT)
      w_rdata = {{(WIDTH-4){1'b0}}, r_ferr, r_ovr, r_rxValid, w_txBusy};
  end

  assign bus.io_din = w_rdata;

endmodule

// File: doc/j1_uart_io.md
# j1_uart_io

Memory-mapped UART responder for the J1 CPU I/O bus. Decodes J1 I/O writes (`io_wr`, `mem_addr`, `dout`) into transmit and receive-acknowledge commands. Returns receive data and status on `io_din` for the CPU's `io_din` ALU operation. Sits beside the core and drives one 8N1 serial line in each direction.

## Interface

Parameters:
- `WIDTH`, 16: CPU data width; matches the core's `WIDTH`.
- `BASE`, 16'h1000: I/O base address; the block decodes `BASE+0` to `BASE+3`.
- `CLKS_PER_BIT`, 217: clock cycles per serial bit. Must be at least 4.

Ports:
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `resetq` in 1: asynchronous, active-low reset.
- `io_wr` in 1: CPU I/O write strobe, one cycle wide.
- `mem_addr` in 16: CPU I/O address, valid together with `io_wr` and for reads.
- `dout` in WIDTH: CPU write data (st1).
- `io_din` out WIDTH: combinational read data selected by `mem_addr`.
- `uart_rx` in 1: asynchronous serial input; idles high.
- `uart_tx` out 1: registered serial output; idles high.

## Operation

Register map:
- `BASE+0` TXDATA (write): `dout[7:0]` is the byte to transmit. It is accepted only when `tx_busy`=0. A write while busy is silently dropped.
- `BASE+1` RXDATA (read): `io_din` = {zeros, `rx_data[7:0]`}.
- `BASE+2` STATUS (read): `io_din` = {zeros, `ferr`, `ovr`, `rx_valid`, `tx_busy`}, with `tx_busy` in bit 0.
- `BASE+3` RXACK (write, data ignored): clears `rx_valid`, `ovr` and `ferr`.
- Reads of any other address return 0. Writes to RXDATA, STATUS or other addresses have no effect.

Transmitter, states IDLE → START → DATA(8) → STOP → IDLE:
- Each state lasts `CLKS_PER_BIT` cycles.
- Bits go out LSB first. `uart_tx` is 0 for the start bit, the data bits in DATA, and 1 for the stop bit.
- `tx_busy`=1 in every state except IDLE.

Receiver:
- `uart_rx` passes through a 2-flop synchronizer.
- States IDLE → START → DATA(8) → STOP → IDLE.
- IDLE: a synchronized 0 starts a half-bit count of `CLKS_PER_BIT/2`, integer division.
- START: the line is re-checked at mid-bit. If it is 1, the event is a glitch: return to IDLE with no flags changed.
- DATA: one sample every `CLKS_PER_BIT` cycles, shifted in LSB first.
- STOP: the stop bit is sampled at mid-bit.
  - Stop=1, `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - Stop=1, `rx_valid`=1: keep the old `rx_data` and set `ovr`.
  - Stop=0: discard the byte and set `ferr`.
- After the stop sample the receiver goes to IDLE. It may detect a new start bit on the next cycle.

Flag behaviour:
- `ovr` and `ferr` are sticky until RXACK.
- Simultaneous RXACK and a byte completing in the same cycle: the new byte is loaded, `rx_valid` stays 1, and `ovr` and `ferr` are cleared. The completion is applied after the ack.

## Timing

- Reset values: `uart_tx`=1, `tx_busy`=0, `rx_valid`=0, `ovr`=0, `ferr`=0, `rx_data`=0. Both state machines are in IDLE and all counters are 0. The synchronizer flops reset to 1.
- Asserting `resetq` mid-frame aborts immediately. `uart_tx` goes high asynchronously and any partial byte is lost.
- Transmit timing:
  - A TXDATA write at edge N makes `tx_busy` and `uart_tx`=0 visible after edge N.
  - The start bit occupies exactly `CLKS_PER_BIT` cycles. The frame lasts `10*CLKS_PER_BIT` cycles.
  - `tx_busy` falls at the end of the stop bit. A TXDATA write in that same cycle (busy still 1) is dropped.
- `io_din` is purely combinational from `mem_addr` and registers, so it is valid in the same cycle the CPU samples it.
- Receive latency: `rx_valid` rises 1 cycle after the mid-stop-bit sample. That is about `9.5*CLKS_PER_BIT`+3 cycles after the falling edge of the start bit on `uart_rx`, including the 2 synchronizer cycles.
- RXACK at edge N makes `rx_valid`=0 visible after edge N.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `BASE`=16'h1000.

- **Reset:** hold `resetq`=0, then release → `uart_tx`=1; STATUS reads 0x0000; RXDATA reads 0x0000; address 0x1004 reads 0.
- **Transmit:** write 0x00A5 to 0x1000 → `uart_tx` sequence, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1,1. STATUS bit0 is 1 for exactly 40 cycles. A second write during busy produces no second frame.
- **Receive:** drive the 8N1 frame for 0x3C on `uart_rx` → STATUS = 0x0002 and RXDATA = 0x003C. A write to 0x1003 → STATUS = 0x0000 on the next cycle.
- **Overrun, then frame error:**
  - Receive 0x11, then 0x22 with no ack → RXDATA = 0x0011, STATUS = 0x0006.
  - Ack, then a frame with stop bit 0 → STATUS = 0x0008.
- **Glitch and ack collision:**
  - A 1-cycle low pulse on `uart_rx` → no state change; STATUS = 0x0000.
  - RXACK issued in the exact cycle a byte 0x5A completes → STATUS = 0x0002 and RXDATA = 0x005A.
- **Reset mid-frame:** assert `resetq` midway through a TX frame and an RX frame → `uart_tx`=1 immediately. After release, STATUS = 0x0000 and a fresh frame is received correctly.
